// File: rtl/udp_tx_sched.sv
// udp_tx_sched -- single-frame UDP transmit scheduler (rgmii_clk domain).
//
// Buffers one payload from a byte producer. On trig it resolves the
// destination MAC through the stack's ARP port, with a per-attempt timeout
// and a bounded number of attempts. It then presents the payload length,
// streams the payload when the stack requests it, waits for the frame to
// leave the wire and holds off for an inter-frame gap.
//
// Ports:
//   rgmii_clk, rstn                 clock, asynchronous active-low reset
//   wr_valid/wr_data/wr_ready       producer byte interface into the buffer
//   trig                            commit buffered bytes as one frame
//   busy                            a committed frame has not finished yet
//   err_no_mac                      sticky ARP failure, cleared by next accepted trig
//   frames_sent                     completed frame counter (wraps)
//   arp_req/arp_found/mac_not_exist ARP handshake with the stack
//   app_data_length                 payload length (padded to MIN_LEN)
//   app_data_request                stack ready for payload
//   app_data_in_valid/app_data_in   payload byte stream
//   udp_send_ack                    stack took the payload (status only)
//   mac_send_end                    frame fully transmitted
module udp_tx_sched #(
  parameter int BUF_DEPTH   = 2048,
  parameter int MIN_LEN     = 18,
  parameter int ARP_TIMEOUT = 125_000_000,
  parameter int ARP_RETRIES = 3,
  parameter int IFG_CYCLES  = 12
) (
  input  logic        rgmii_clk,
  input  logic        rstn,
  input  logic        wr_valid,
  input  logic [7:0]  wr_data,
  output logic        wr_ready,
  input  logic        trig,
  output logic        busy,
  output logic        err_no_mac,
  output logic [15:0] frames_sent,
  output logic        arp_req,
  input  logic        arp_found,
  input  logic        mac_not_exist,
  output logic [15:0] app_data_length,
  input  logic        app_data_request,
  output logic        app_data_in_valid,
  output logic [7:0]  app_data_in,
  input  logic        udp_send_ack,
  input  logic        mac_send_end
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int TW = $clog2(ARP_TIMEOUT + 1);
  localparam int RW = $clog2(ARP_RETRIES + 1);
  localparam int GW = $clog2(IFG_CYCLES + 1);

  localparam logic [CW-1:0] DEPTH_C  = CW'(BUF_DEPTH);
  localparam logic [CW-1:0] MINLEN_C = CW'(MIN_LEN);
  localparam logic [TW-1:0] TO_LAST  = TW'(ARP_TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_C  = RW'(ARP_RETRIES);
  localparam logic [GW-1:0] GAP_LAST = GW'(IFG_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_ARP, S_ARP_WAIT, S_LEN,
    S_WAIT_REQ, S_STREAM, S_WAIT_END, S_GAP
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   len_q, len_d;
  logic [CW-1:0]   rd_idx_q, rd_idx_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [RW-1:0]   tries_q, tries_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            end_seen_q, end_seen_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;
  logic [15:0]     frames_q, frames_d;
  logic            arp_req_q, arp_req_d;
  logic [15:0]     len_out_q, len_out_d;
  logic            vld_q, vld_d;
  logic [7:0]      dout_q, dout_d;
  logic            wr_ready_q, wr_ready_d;

  logic [7:0]      mem [BUF_DEPTH];
  logic [7:0]      ram_q;
  logic            wr_en;
  logic [CW-1:0]   count_inc;
  logic            unused_ack;

  // The ack carries no scheduling meaning here; the frame is closed by mac_send_end.
  assign unused_ack = udp_send_ack;

  // wr_ready_q is only ever high in IDLE, so this also gates writes by state.
  assign wr_en     = wr_valid & wr_ready_q;
  assign count_inc = count_q + CW'(wr_en);

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    len_d      = len_q;
    rd_idx_d   = rd_idx_q;
    timer_d    = timer_q;
    tries_d    = tries_q;
    gap_d      = gap_q;
    end_seen_d = end_seen_q;
    busy_d     = busy_q;
    err_d      = err_q;
    frames_d   = frames_q;
    len_out_d  = len_out_q;
    vld_d      = 1'b0;
    dout_d     = 8'h00;

    case (state_q)
      S_IDLE: begin
        if (wr_en) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          count_d  = count_inc;
        end
        // A byte written in the trig cycle belongs to this frame.
        if (trig && (count_inc != '0)) begin
          state_d  = S_CHECK;
          len_d    = (count_inc < MINLEN_C) ? MINLEN_C : count_inc;
          busy_d   = 1'b1;
          err_d    = 1'b0;
          tries_d  = '0;
          rd_idx_d = '0;
        end
      end
      S_CHECK: state_d = arp_found ? S_LEN : S_ARP;
      S_ARP: begin
        tries_d = tries_q + 1'b1;
        // Timer counts cycles since the request pulse, so the pulse cycle is 1.
        timer_d = TW'(1);
        state_d = S_ARP_WAIT;
      end
      S_ARP_WAIT: begin
        timer_d = timer_q + 1'b1;
        if (arp_found) begin
          state_d = S_LEN;
        end else if (mac_not_exist || (timer_q == TO_LAST)) begin
          if (tries_q < RETRY_C) begin
            state_d = S_ARP;
          end else begin
            state_d  = S_IDLE;
            err_d    = 1'b1;
            busy_d   = 1'b0;
            count_d  = '0;
            wr_ptr_d = '0;
          end
        end
      end
      S_LEN: begin
        rd_idx_d = '0;
        state_d  = S_WAIT_REQ;
      end
      S_WAIT_REQ: begin
        end_seen_d = 1'b0;
        if (app_data_request) begin
          vld_d    = 1'b1;
          dout_d   = (rd_idx_q < count_q) ? ram_q : 8'h00;
          rd_idx_d = rd_idx_q + 1'b1;
          state_d  = S_STREAM;
        end
      end
      S_STREAM: begin
        // The stack may report frame end in the last streaming cycle.
        if (mac_send_end) end_seen_d = 1'b1;
        if (rd_idx_q < len_q) begin
          vld_d    = 1'b1;
          dout_d   = (rd_idx_q < count_q) ? ram_q : 8'h00;
          rd_idx_d = rd_idx_q + 1'b1;
        end else begin
          state_d = S_WAIT_END;
        end
      end
      S_WAIT_END: begin
        if (mac_send_end || end_seen_q) begin
          frames_d   = frames_q + 16'd1;
          gap_d      = '0;
          end_seen_d = 1'b0;
          state_d    = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d  = S_IDLE;
          busy_d   = 1'b0;
          count_d  = '0;
          wr_ptr_d = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_LEN) len_out_d = 16'(len_q);
    arp_req_d  = (state_d == S_ARP);
    wr_ready_d = (state_d == S_IDLE) && (count_d < DEPTH_C);
  end

  always_ff @(posedge rgmii_clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      len_q      <= '0;
      rd_idx_q   <= '0;
      timer_q    <= '0;
      tries_q    <= '0;
      gap_q      <= '0;
      end_seen_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      frames_q   <= '0;
      arp_req_q  <= 1'b0;
      len_out_q  <= '0;
      vld_q      <= 1'b0;
      dout_q     <= '0;
      wr_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      len_q      <= len_d;
      rd_idx_q   <= rd_idx_d;
      timer_q    <= timer_d;
      tries_q    <= tries_d;
      gap_q      <= gap_d;
      end_seen_q <= end_seen_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      frames_q   <= frames_d;
      arp_req_q  <= arp_req_d;
      len_out_q  <= len_out_d;
      vld_q      <= vld_d;
      dout_q     <= dout_d;
      wr_ready_q <= wr_ready_d;
    end
  end

  // Payload RAM: synchronous read addressed by the next read index so the
  // byte for the following stream cycle is already in ram_q.
  always_ff @(posedge rgmii_clk) begin
    if (wr_en) mem[wr_ptr_q] <= wr_data;
    ram_q <= mem[rd_idx_d[AW-1:0]];
  end

  assign wr_ready          = wr_ready_q;
  assign busy              = busy_q;
  assign err_no_mac        = err_q;
  assign frames_sent       = frames_q;
  assign arp_req           = arp_req_q;
  assign app_data_length   = len_out_q;
  assign app_data_in_valid = vld_q;
  assign app_data_in       = dout_q;

endmodule
